wb_stage: RTL

//  Write-back stage. Sole driver of the regfile write port (w_addr/w_data/w_ena).

---
 rtl/wb_stage.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// wb_stage: write-back stage, sole driver of the regfile write port.
//   ALU results retire one per cycle. A load is parked in WAIT_MEM until
//   its memory response arrives, then it is aligned, extended and written.
//   Each retiring instruction produces exactly one registered retire pulse
//   and at most one registered write.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wb_valid_i/_ready_o handshake with the mem stage (accept = valid & ready)
//   wb_rd_i, wb_wen_i   destination register and write intent
//   wb_is_load_i        result comes from the memory response
//   wb_ld_type_i        load funct3 (LB/LH/LW/LD/LBU/LHU/LWU)
//   wb_addr_off_i       load address bits [2:0]
//   wb_alu_res_i        ALU result for non-loads
//   mem_rvalid_i        one-cycle load response strobe
//   mem_rdata_i         doubleword holding the load data
//   w_addr_o/w_data_o/w_ena_o  regfile write port
//   retire_o            one pulse per completed instruction
//   err_o               sticky error flag, cleared only by rst
module wb_stage #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid_i,
    output logic            wb_ready_o,
    input  logic [4:0]      wb_rd_i,
    input  logic            wb_wen_i,
    input  logic            wb_is_load_i,
    input  logic [2:0]      wb_ld_type_i,
    input  logic [2:0]      wb_addr_off_i,
    input  logic [XLEN-1:0] wb_alu_res_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic [4:0]      w_addr_o,
    output logic [XLEN-1:0] w_data_o,
    output logic            w_ena_o,
    output logic            retire_o,
    output logic            err_o
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned RD_W    = 5;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] LT_B  = 3'b000;
    localparam logic [2:0] LT_H  = 3'b001;
    localparam logic [2:0] LT_W  = 3'b010;
    localparam logic [2:0] LT_D  = 3'b011;
    localparam logic [2:0] LT_BU = 3'b100;
    localparam logic [2:0] LT_HU = 3'b101;
    localparam logic [2:0] LT_WU = 3'b110;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Context of the load parked in WAIT_MEM
    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic            wen;
        logic [2:0]      typ;
        logic [2:0]      off;
    } ld_ctx_t;

    state_t          state_q, state_d;
    ld_ctx_t         ld_q, ld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RD_W-1:0] w_addr_d;
    logic [XLEN-1:0] w_data_d;
    logic            w_ena_d;
    logic            retire_d;
    logic            err_d;
    logic            accept;

    // Misaligned offsets and the unused funct3 encoding are load errors
    function automatic logic ld_bad(input logic [2:0] typ, input logic [2:0] off);
        logic bad;
        bad = 1'b0;
        case (typ)
            LT_B, LT_BU: bad = 1'b0;
            LT_H, LT_HU: bad = off[0];
            LT_W, LT_WU: bad = (off[1:0] != 2'b00);
            LT_D:        bad = (off != 3'b000);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Select the addressed lane of the doubleword and extend it to XLEN
    function automatic logic [XLEN-1:0] ld_extract(input logic [2:0]      typ,
                                                   input logic [2:0]      off,
                                                   input logic [XLEN-1:0] rdata);
        logic [XLEN-1:0] b_sh;
        logic [XLEN-1:0] h_sh;
        logic [XLEN-1:0] w_sh;
        logic [XLEN-1:0] res;
        b_sh = rdata >> {off, 3'b000};
        h_sh = rdata >> {off[2:1], 4'b0000};
        w_sh = rdata >> {off[2], 5'b00000};
        case (typ)
            LT_B:    res = {{(XLEN-8){b_sh[7]}}, b_sh[7:0]};
            LT_BU:   res = {{(XLEN-8){1'b0}}, b_sh[7:0]};
            LT_H:    res = {{(XLEN-16){h_sh[15]}}, h_sh[15:0]};
            LT_HU:   res = {{(XLEN-16){1'b0}}, h_sh[15:0]};
            LT_W:    res = {{(XLEN-32){w_sh[31]}}, w_sh[31:0]};
            LT_WU:   res = {{(XLEN-32){1'b0}}, w_sh[31:0]};
            default: res = rdata;
        endcase
        return res;
    endfunction

    // Ready depends on state only, so upstream never sees a combinational loop
    assign wb_ready_o = (state_q == S_IDLE);
    assign accept     = wb_valid_i && wb_ready_o;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ld_q     <= '0;
            cnt_q    <= '0;
            w_addr_o <= '0;
            w_data_o <= '0;
            w_ena_o  <= 1'b0;
            retire_o <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_q     <= ld_d;
            cnt_q    <= cnt_d;
            w_addr_o <= w_addr_d;
            w_data_o <= w_data_d;
            w_ena_o  <= w_ena_d;
            retire_o <= retire_d;
            err_o    <= err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        ld_d     = ld_q;
        cnt_d    = cnt_q;
        w_addr_d = w_addr_o;
        w_data_d = w_data_o;
        w_ena_d  = 1'b0;
        retire_d = 1'b0;
        err_d    = err_o;

        case (state_q)
            S_IDLE: begin
                // A response with no load outstanding carries no usable data
                if (mem_rvalid_i) begin
                    err_d = 1'b1;
                end
                if (accept) begin
                    if (!wb_is_load_i) begin
                        retire_d = 1'b1;
                        w_ena_d  = wb_wen_i && (wb_rd_i != '0);
                        w_addr_d = wb_rd_i;
                        w_data_d = wb_alu_res_i;
                    end else if (ld_bad(wb_ld_type_i, wb_addr_off_i)) begin
                        // Faulting loads retire immediately without parking
                        err_d    = 1'b1;
                        retire_d = 1'b1;
                    end else begin
                        ld_d.rd  = wb_rd_i;
                        ld_d.wen = wb_wen_i;
                        ld_d.typ = wb_ld_type_i;
                        ld_d.off = wb_addr_off_i;
                        cnt_d    = '0;
                        state_d  = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (mem_rvalid_i) begin
                    retire_d = 1'b1;
                    w_ena_d  = ld_q.wen && (ld_q.rd != '0);
                    w_addr_d = ld_q.rd;
                    w_data_d = ld_extract(ld_q.typ, ld_q.off, mem_rdata_i);
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end else if (cnt_q == TO_LAST) begin
                    // Response never came: abandon the load without writing
                    err_d    = 1'b1;
                    retire_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
